// File: rtl/bram_pkg.sv
// -----------------------------------------------------------------------------
// bram_pkg
// Shared types and elaboration-time helpers for the tiled dual-port RAM.
//   wr_mode_e : same-port read-during-write behaviour (RD_FIRST / WR_FIRST)
//   state_e   : post-reset clear sweep FSM states (INIT / RUN)
//   clog2     : address width for a word count, never less than 1 bit
//   ceil_div  : bank count for a depth that is not a multiple of the bank size
// -----------------------------------------------------------------------------
package bram_pkg;

   typedef enum logic {
      RD_FIRST = 1'b0,
      WR_FIRST = 1'b1
   } wr_mode_e;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(n)) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/bram_dp_bank.sv
// -----------------------------------------------------------------------------
// bram_dp_bank
// One BANK_DEPTH x WIDTH true dual-port bank with per-bit write enables.
//   clk            : rising-edge clock
//   ceN / weN      : port access enable / write enable
//   aN             : bank-local word address
//   dN / wemN      : write data / per-bit write mask
//   qN             : registered read data, updated only on accesses
// Cross-port reads always see the pre-edge contents. Same-port read during
// write returns old data (RD_FIRST) or the merged new word (WR_FIRST).
// When both ports write one word, port 1 wins on bits both masks select.
// -----------------------------------------------------------------------------
module bram_dp_bank
   import bram_pkg::*;
#(
   parameter int WIDTH      = 1,
   parameter int BANK_DEPTH = 4096,
   parameter int WR_MODE    = 0,
   parameter int BAW        = clog2(BANK_DEPTH)
) (
   input  logic             clk,
   input  logic             ce0,
   input  logic             we0,
   input  logic [BAW-1:0]   a0,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] wem0,
   output logic [WIDTH-1:0] q0,
   input  logic             ce1,
   input  logic             we1,
   input  logic [BAW-1:0]   a1,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] wem1,
   output logic [WIDTH-1:0] q1
);

   logic [WIDTH-1:0] mem [BANK_DEPTH];

   // Bit-granular writes; port 1 is applied last so it owns shared bits.
   always_ff @(posedge clk) begin
      for (int i = 0; i < WIDTH; i++) begin
         if (ce0 && we0 && wem0[i]) mem[a0][i] <= d0[i];
         if (ce1 && we1 && wem1[i]) mem[a1][i] <= d1[i];
      end
   end

   always_ff @(posedge clk) begin
      if (ce0) begin
         if (WR_MODE == int'(WR_FIRST) && we0) q0 <= (mem[a0] & ~wem0) | (d0 & wem0);
         else                                  q0 <= mem[a0];
      end
      if (ce1) begin
         if (WR_MODE == int'(WR_FIRST) && we1) q1 <= (mem[a1] & ~wem1) | (d1 & wem1);
         else                                  q1 <= mem[a1];
      end
   end

endmodule

// File: rtl/bram_dp_tiled.sv
// -----------------------------------------------------------------------------
// bram_dp_tiled
// Parametrised true dual-port synchronous RAM tiled from BANK_DEPTH banks,
// with per-bit write masks, collision flag and a post-reset clear sweep.
//   CLK, RSTN          : clock, synchronous active-low reset
//   A0/A1, D0/D1       : port addresses and write data
//   WEM0/WEM1          : per-bit write masks
//   WE0/WE1, CE0/CE1   : write enables (qualified by CE), port enables
//   Q0/Q1              : read data (holds while CE is low)
//   COLL               : same-address access with a write on either port
//   INIT_BUSY          : clear sweep in progress, external accesses ignored
// Build option: define BRAM_OUTREG_EN to add an output register on Q0, Q1 and
// COLL (read latency 2 instead of 1).
// -----------------------------------------------------------------------------
module bram_dp_tiled
   import bram_pkg::*;
#(
   parameter  int WIDTH      = 1,
   parameter  int DEPTH      = 16384,
   parameter  int BANK_DEPTH = 4096,
   parameter  int WR_MODE    = 0,
   localparam int AW         = clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic [AW-1:0]    A0,
   input  logic [AW-1:0]    A1,
   input  logic [WIDTH-1:0] D0,
   input  logic [WIDTH-1:0] D1,
   input  logic [WIDTH-1:0] WEM0,
   input  logic [WIDTH-1:0] WEM1,
   input  logic             WE0,
   input  logic             WE1,
   input  logic             CE0,
   input  logic             CE1,
   output logic [WIDTH-1:0] Q0,
   output logic [WIDTH-1:0] Q1,
   output logic             COLL,
   output logic             INIT_BUSY
);

   localparam int NBANK = ceil_div(DEPTH, BANK_DEPTH);
   localparam int BAW   = clog2(BANK_DEPTH);
   localparam int SW    = clog2(NBANK);

   state_e        state, state_nxt;
   logic [AW-1:0] cnt;
   logic          run;

   assign run       = (state == RUN);
   assign INIT_BUSY = !run;

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == INIT) cnt <= cnt + AW'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         INIT:    if (32'(cnt) == 32'(DEPTH - 1)) state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = INIT;
      endcase
   end

   // During the sweep port 0 is taken over to write zeros at the counter.
   logic [AW-1:0]    p0_a;
   logic             p0_ce, p0_we, p1_ce;
   logic [WIDTH-1:0] p0_d, p0_m;
   logic             in0, in1;

   always_comb begin
      p0_a  = A0;
      p0_ce = CE0;
      p0_we = WE0;
      p0_d  = D0;
      p0_m  = WEM0;
      if (!run) begin
         p0_a  = cnt;
         p0_ce = 1'b1;
         p0_we = 1'b1;
         p0_d  = '0;
         p0_m  = '1;
      end
   end

   assign p1_ce = run & CE1;
   assign in0   = 32'(p0_a) < 32'(DEPTH);
   assign in1   = 32'(A1) < 32'(DEPTH);

   logic [WIDTH-1:0] bq0 [NBANK];
   logic [WIDTH-1:0] bq1 [NBANK];

   for (genvar b = 0; b < NBANK; b++) begin : g_bank
      logic hit0, hit1;
      assign hit0 = p0_ce && in0 && (32'(p0_a) / 32'(BANK_DEPTH) == 32'(b));
      assign hit1 = p1_ce && in1 && (32'(A1) / 32'(BANK_DEPTH) == 32'(b));

      bram_dp_bank #(
         .WIDTH      (WIDTH),
         .BANK_DEPTH (BANK_DEPTH),
         .WR_MODE    (WR_MODE),
         .BAW        (BAW)
      ) u_bank (
         .clk  (CLK),
         .ce0  (hit0),
         .we0  (p0_we),
         .a0   (BAW'(32'(p0_a) % 32'(BANK_DEPTH))),
         .d0   (p0_d),
         .wem0 (p0_m),
         .q0   (bq0[b]),
         .ce1  (hit1),
         .we1  (WE1),
         .a1   (BAW'(32'(A1) % 32'(BANK_DEPTH))),
         .d1   (D1),
         .wem1 (WEM1),
         .q1   (bq1[b])
      );
   end

   // ---- stage p1: bank select / out-of-range flag registered with the read
   logic [SW-1:0]    sel0_p1, sel1_p1;
   logic             zero0_p1, zero1_p1, coll_p1;
   logic [WIDTH-1:0] q0_p1, q1_p1;

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         sel0_p1  <= '0;
         sel1_p1  <= '0;
         zero0_p1 <= 1'b1;
         zero1_p1 <= 1'b1;
         coll_p1  <= 1'b0;
      end else begin
         coll_p1 <= run & CE0 & CE1 & (A0 == A1) & (WE0 | WE1);
         if (!run) begin
            zero0_p1 <= 1'b1;
            zero1_p1 <= 1'b1;
         end else begin
            if (CE0) begin
               zero0_p1 <= !in0;
               sel0_p1  <= SW'(32'(A0) / 32'(BANK_DEPTH));
            end
            if (CE1) begin
               zero1_p1 <= !in1;
               sel1_p1  <= SW'(32'(A1) / 32'(BANK_DEPTH));
            end
         end
      end
   end

   always_comb begin
      q0_p1 = '0;
      q1_p1 = '0;
      for (int b = 0; b < NBANK; b++) begin
         if (!zero0_p1 && sel0_p1 == SW'(b)) q0_p1 = bq0[b];
         if (!zero1_p1 && sel1_p1 == SW'(b)) q1_p1 = bq1[b];
      end
   end

`ifdef BRAM_OUTREG_EN
   // ---- stage p2: optional output register, always enabled
   logic [WIDTH-1:0] q0_p2, q1_p2;
   logic             coll_p2;

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         q0_p2   <= '0;
         q1_p2   <= '0;
         coll_p2 <= 1'b0;
      end else begin
         q0_p2   <= q0_p1;
         q1_p2   <= q1_p1;
         coll_p2 <= coll_p1;
      end
   end

   assign Q0   = q0_p2;
   assign Q1   = q1_p2;
   assign COLL = coll_p2;
`else
   assign Q0   = q0_p1;
   assign Q1   = q1_p1;
   assign COLL = coll_p1;
`endif

endmodule

// File: tb/tb_bram_dp_tiled.sv
// -----------------------------------------------------------------------------
// tb_bram_dp_tiled
// Two instances driven by the same vectors: A (16384 words, read-first) and
// B (5000 words, write-first, non-power-of-two depth). An array-level model
// predicts every output each cycle; directed steps add literal expectations.
// -----------------------------------------------------------------------------
module tb_bram_dp_tiled;

   localparam int W  = 4;
   localparam int DA = 16384;
   localparam int DB = 5000;
   localparam int BD = 4096;
`ifdef BRAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstn;
   logic [13:0]   a0, a1;
   logic [W-1:0]  d0, d1, wem0, wem1;
   logic          we0, we1, ce0, ce1;
   logic [W-1:0]  qa0, qa1, qb0, qb1;
   logic          colla, collb, busya, busyb;

   bram_dp_tiled #(.WIDTH(W), .DEPTH(DA), .BANK_DEPTH(BD), .WR_MODE(0)) u_a (
      .CLK(clk), .RSTN(rstn), .A0(a0), .A1(a1), .D0(d0), .D1(d1),
      .WEM0(wem0), .WEM1(wem1), .WE0(we0), .WE1(we1), .CE0(ce0), .CE1(ce1),
      .Q0(qa0), .Q1(qa1), .COLL(colla), .INIT_BUSY(busya));

   bram_dp_tiled #(.WIDTH(W), .DEPTH(DB), .BANK_DEPTH(BD), .WR_MODE(1)) u_b (
      .CLK(clk), .RSTN(rstn), .A0(a0[12:0]), .A1(a1[12:0]), .D0(d0), .D1(d1),
      .WEM0(wem0), .WEM1(wem1), .WE0(we0), .WE1(we1), .CE0(ce0), .CE1(ce1),
      .Q0(qb0), .Q1(qb1), .COLL(collb), .INIT_BUSY(busyb));

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [W-1:0] mm [2][16384];
   int           m_depth [2] = '{DA, DB};
   int           m_amask [2] = '{16383, 8191};
   int           m_wrm   [2] = '{0, 1};
   bit           m_init  [2];
   int           m_cnt   [2];
   logic [W-1:0] e_q0 [2], e_q1 [2], r_q0 [2], r_q1 [2];
   logic         e_coll [2], r_coll [2];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int           x0, x1;
         bit           v0, v1;
         logic [W-1:0] o0, o1;
         r_q0[k]   = rstn ? e_q0[k]   : '0;
         r_q1[k]   = rstn ? e_q1[k]   : '0;
         r_coll[k] = rstn ? e_coll[k] : 1'b0;
         if (!rstn) begin
            m_init[k] = 1'b1; m_cnt[k] = 0;
            e_q0[k] = '0; e_q1[k] = '0; e_coll[k] = 1'b0;
         end else if (m_init[k]) begin
            e_coll[k] = 1'b0;
            m_cnt[k]++;
            if (m_cnt[k] == m_depth[k]) begin
               m_init[k] = 1'b0;
               for (int i = 0; i < 16384; i++) mm[k][i] = '0;
            end
         end else begin
            x0 = int'(a0) & m_amask[k];
            x1 = int'(a1) & m_amask[k];
            v0 = x0 < m_depth[k];
            v1 = x1 < m_depth[k];
            o0 = v0 ? mm[k][x0] : '0;
            o1 = v1 ? mm[k][x1] : '0;
            e_coll[k] = ce0 && ce1 && (x0 == x1) && (we0 || we1);
            if (ce0) e_q0[k] = !v0 ? '0 : (we0 && m_wrm[k] == 1) ? ((o0 & ~wem0) | (d0 & wem0)) : o0;
            if (ce1) e_q1[k] = !v1 ? '0 : (we1 && m_wrm[k] == 1) ? ((o1 & ~wem1) | (d1 & wem1)) : o1;
            if (ce0 && we0 && v0) mm[k][x0] = (mm[k][x0] & ~wem0) | (d0 & wem0);
            if (ce1 && we1 && v1) mm[k][x1] = (mm[k][x1] & ~wem1) | (d1 & wem1);
         end
      end
   end

   function automatic logic [W-1:0] xq0(input int k);
      return (LAT == 2) ? r_q0[k] : e_q0[k];
   endfunction
   function automatic logic [W-1:0] xq1(input int k);
      return (LAT == 2) ? r_q1[k] : e_q1[k];
   endfunction
   function automatic logic xcoll(input int k);
      return (LAT == 2) ? r_coll[k] : e_coll[k];
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("A.Q0", qa0, xq0(0));
         chk("A.Q1", qa1, xq1(0));
         chk("A.COLL", colla, xcoll(0));
         chk("A.INIT_BUSY", busya, m_init[0]);
         chk("B.Q0", qb0, xq0(1));
         chk("B.Q1", qb1, xq1(1));
         chk("B.COLL", collb, xcoll(1));
         chk("B.INIT_BUSY", busyb, m_init[1]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ce0 = 1'b0; ce1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
   endtask

   // Let an access driven now become visible on Q, then park at a negedge.
   task automatic settle();
      step();
      idle();
      if (LAT == 2) step();
      @(negedge clk);
   endtask

   task automatic wr0(input int a, input int d, input int m);
      a0 = 14'(a); d0 = W'(d); wem0 = W'(m); we0 = 1'b1; ce0 = 1'b1;
   endtask
   task automatic wr1(input int a, input int d, input int m);
      a1 = 14'(a); d1 = W'(d); wem1 = W'(m); we1 = 1'b1; ce1 = 1'b1;
   endtask

   int n_a, n_b;

   initial begin
      rstn = 1'b0;
      a0 = '0; a1 = '0; d0 = '0; d1 = '0; wem0 = '0; wem1 = '0;
      idle();
      repeat (3) step();
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_busy", busya, 1);
      chk("rst_q0", qa0, 0);
      chk("rst_coll", colla, 0);

      // partial sweep, then reset restarts it
      step();
      rstn = 1'b1;
      repeat (1000) step();
      @(negedge clk);
      chk("mid_busy_a", busya, 1);
      chk("mid_busy_b", busyb, 1);
      rstn = 1'b0;
      repeat (2) step();
      rstn = 1'b1;

      n_a = 0; n_b = 0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (busya) n_a++;
         if (busyb) n_b++;
         if (!busya && !busyb) break;
      end
      chk("init_len_a", n_a, DA);
      chk("init_len_b", n_b, DB);

      // cleared contents
      a0 = 14'd0;     ce0 = 1'b1; settle(); chk("clr_0", qa0, 0);
      a0 = 14'd100;   ce0 = 1'b1; settle(); chk("clr_100", qa0, 0);
      a0 = 14'd16383; ce0 = 1'b1; settle(); chk("clr_16383", qa0, 0);

      // masked write
      wr0(5, 'hF, 'hA); step(); idle();
      a1 = 14'd5; ce1 = 1'b1; settle();
      chk("mask_a", qa1, 'hA);
      chk("mask_b", qb1, 'hA);

      // same-port read during write
      wr0(7, 'h1, 'hF); step(); idle();
      wr0(7, 'h3, 'hF); settle();
      chk("rdw_rdfirst", qa0, 'h1);
      chk("rdw_wrfirst", qb0, 'h3);
      a0 = 14'd7; ce0 = 1'b1; settle();
      chk("rdw_after", qa0, 'h3);

      // collision: port 0 writes, port 1 reads old data
      wr0(9, 'h2, 'hF); step(); idle();
      wr0(9, 'h5, 'hF); a1 = 14'd9; ce1 = 1'b1; settle();
      chk("coll_q1_a", qa1, 'h2);
      chk("coll_q1_b", qb1, 'h2);
      chk("coll_flag_a", colla, 1);
      chk("coll_flag_b", collb, 1);
      step(); @(negedge clk);
      chk("coll_pulse", colla, 0);
      a0 = 14'd9; ce0 = 1'b1; settle();
      chk("coll_wr0", qa0, 'h5);

      // dual writes, port 1 owns shared bits
      wr0(11, 'h5, 'hF); wr1(11, 'h6, 'hF); step(); idle();
      a0 = 14'd11; ce0 = 1'b1; settle();
      chk("dual_full", qa0, 'h6);
      wr0(12, 'hF, 'h3); wr1(12, 'h0, 'h6); step(); idle();
      a0 = 14'd12; ce0 = 1'b1; settle();
      chk("dual_mask", qa0, 'h1);

      // bank boundary and out-of-range
      wr0(4095, 'hC, 'hF); wr1(4096, 'h3, 'hF); step(); idle();
      a0 = 14'd4095; ce0 = 1'b1; a1 = 14'd4096; ce1 = 1'b1; settle();
      chk("bank_lo_b", qb0, 'hC);
      chk("bank_hi_b", qb1, 'h3);
      chk("bank_lo_a", qa0, 'hC);
      wr0(5000, 'hF, 'hF); step(); idle();
      a0 = 14'd5000; ce0 = 1'b1; settle();
      chk("oor_b", qb0, 'h0);
      chk("inrange_a", qa0, 'hF);
      a1 = 14'd4096; ce1 = 1'b1; settle();
      chk("oor_no_alias", qb1, 'h3);

      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
